// File: rtl/battle_sequencer.sv
// Frame-synchronous battle controller: sequences dodge and attack phases,
// debounces bullet hits, and owns the player and monster HP registers.
module battle_sequencer #(
  parameter int unsigned DODGE_FRAMES    = 300,
  parameter int unsigned ATTACK_FRAMES   = 180,
  parameter int unsigned PLAYER_HP_INIT  = 100,
  parameter int unsigned MONSTER_HP_INIT = 100,
  parameter int unsigned BULLET_DAMAGE   = 10,
  parameter int unsigned IFRAMES         = 30
) (
  input  logic       Pclk,
  input  logic       RESET,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       ovl_b1,
  input  logic       ovl_b2,
  input  logic       attack,
  input  logic [6:0] attack_damage,
  output logic       state_game,
  output logic       hit_b1,
  output logic       hit_b2,
  output logic [6:0] player_hp,
  output logic [6:0] monster_hp,
  output logic       game_over,
  output logic       game_win
);

  typedef enum logic [2:0] {IDLE, DODGE, AIM, RESOLVE, LOSE, WIN} state_t;

  localparam logic [8:0] DODGE_LOAD  = 9'(DODGE_FRAMES - 1);
  localparam logic [8:0] ATTACK_LOAD = 9'(ATTACK_FRAMES - 1);
  localparam logic [6:0] P_INIT      = 7'(PLAYER_HP_INIT);
  localparam logic [6:0] M_INIT      = 7'(MONSTER_HP_INIT);
  localparam logic [6:0] B_DMG       = 7'(BULLET_DAMAGE);
  localparam logic [5:0] IFR_LOAD    = 6'(IFRAMES);

  // HP subtraction in 8 bits; a negative result clamps to zero.
  function automatic logic [6:0] sat_sub(input logic [6:0] a, input logic [6:0] b);
    logic signed [7:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? 7'd0 : diff[6:0];
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  iframe_cnt_q, iframe_cnt_d;
  logic [6:0]  dmg_q, dmg_d;
  logic        b1_done_q, b1_done_d, b2_done_q, b2_done_d;
  logic [6:0]  player_hp_q, player_hp_d, monster_hp_q, monster_hp_d;
  logic        hit_b1_q, hit_b1_d, hit_b2_q, hit_b2_d;
  logic        state_game_q, state_game_d, game_over_q, game_over_d, game_win_q, game_win_d;
  logic        acc_b1, acc_b2;
  logic [6:0]  hit_hp, res_hp;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    iframe_cnt_d = iframe_cnt_q;
    dmg_d        = dmg_q;
    b1_done_d    = b1_done_q;
    b2_done_d    = b2_done_q;
    player_hp_d  = player_hp_q;
    monster_hp_d = monster_hp_q;
    hit_b1_d     = 1'b0;
    hit_b2_d     = 1'b0;
    acc_b1       = 1'b0;
    acc_b2       = 1'b0;
    hit_hp       = sat_sub(player_hp_q, B_DMG);
    res_hp       = sat_sub(monster_hp_q, dmg_q);

    if (start) begin
      state_d      = DODGE;
      player_hp_d  = P_INIT;
      monster_hp_d = M_INIT;
      frame_cnt_d  = DODGE_LOAD;
      iframe_cnt_d = 6'd0;
      b1_done_d    = 1'b0;
      b2_done_d    = 1'b0;
    end else begin
      case (state_q)
        DODGE: begin
          // b1 has precedence; the iframe window it opens then shields b2.
          acc_b1 = ovl_b1 && !b1_done_q && (iframe_cnt_q == 6'd0);
          acc_b2 = ovl_b2 && !b2_done_q && (iframe_cnt_q == 6'd0) && !acc_b1;
          if (frame_tick) begin
            if (iframe_cnt_q != 6'd0) iframe_cnt_d = iframe_cnt_q - 6'd1;
            if (frame_cnt_q == 9'd0) begin
              state_d     = AIM;
              frame_cnt_d = ATTACK_LOAD;
            end else begin
              frame_cnt_d = frame_cnt_q - 9'd1;
            end
          end
          if (acc_b1 || acc_b2) begin
            hit_b1_d     = acc_b1;
            hit_b2_d     = acc_b2;
            b1_done_d    = b1_done_q | acc_b1;
            b2_done_d    = b2_done_q | acc_b2;
            iframe_cnt_d = IFR_LOAD;
            player_hp_d  = hit_hp;
            if (hit_hp == 7'd0) state_d = LOSE;
          end
        end
        AIM: begin
          if (attack) begin
            dmg_d   = attack_damage;
            state_d = RESOLVE;
          end else if (frame_tick) begin
            if (frame_cnt_q == 9'd0) begin
              dmg_d   = 7'd0;
              state_d = RESOLVE;
            end else begin
              frame_cnt_d = frame_cnt_q - 9'd1;
            end
          end
        end
        RESOLVE: begin
          monster_hp_d = res_hp;
          if (res_hp == 7'd0) begin
            state_d = WIN;
          end else begin
            state_d      = DODGE;
            frame_cnt_d  = DODGE_LOAD;
            iframe_cnt_d = 6'd0;
            b1_done_d    = 1'b0;
            b2_done_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end

    state_game_d = (state_d == AIM) || (state_d == RESOLVE);
    game_over_d  = (state_d == LOSE);
    game_win_d   = (state_d == WIN);
  end

  always_ff @(posedge Pclk) begin
    if (!RESET) begin
      state_q      <= IDLE;
      frame_cnt_q  <= 9'd0;
      iframe_cnt_q <= 6'd0;
      b1_done_q    <= 1'b0;
      b2_done_q    <= 1'b0;
      player_hp_q  <= P_INIT;
      monster_hp_q <= M_INIT;
      hit_b1_q     <= 1'b0;
      hit_b2_q     <= 1'b0;
      state_game_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_win_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      iframe_cnt_q <= iframe_cnt_d;
      b1_done_q    <= b1_done_d;
      b2_done_q    <= b2_done_d;
      player_hp_q  <= player_hp_d;
      monster_hp_q <= monster_hp_d;
      hit_b1_q     <= hit_b1_d;
      hit_b2_q     <= hit_b2_d;
      state_game_q <= state_game_d;
      game_over_q  <= game_over_d;
      game_win_q   <= game_win_d;
    end
  end

  // Damage latch is pure data: only read in RESOLVE, always written in AIM first.
  always_ff @(posedge Pclk) begin
    dmg_q <= dmg_d;
  end

  assign state_game = state_game_q;
  assign hit_b1     = hit_b1_q;
  assign hit_b2     = hit_b2_q;
  assign player_hp  = player_hp_q;
  assign monster_hp = monster_hp_q;
  assign game_over  = game_over_q;
  assign game_win   = game_win_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: one default-sized instance for the main
// game flow and a short-phase instance for the lose path.
module tb_battle_sequencer;

  logic       Pclk = 1'b0;
  logic       RESET;
  logic       frame_tick, start, ovl_b1, ovl_b2, attack;
  logic [6:0] attack_damage;
  logic       state_game, hit_b1, hit_b2, game_over, game_win;
  logic [6:0] player_hp, monster_hp;

  logic       frame_tick2, start2, ovl2_b1, ovl2_b2, attack2;
  logic [6:0] attack_damage2;
  logic       state_game2, hit2_b1, hit2_b2, game_over2, game_win2;
  logic [6:0] player_hp2, monster_hp2;

  int total = 0;
  int bad   = 0;

  always #5 Pclk = ~Pclk;

  battle_sequencer u_dut (
    .Pclk(Pclk), .RESET(RESET), .frame_tick(frame_tick), .start(start),
    .ovl_b1(ovl_b1), .ovl_b2(ovl_b2), .attack(attack), .attack_damage(attack_damage),
    .state_game(state_game), .hit_b1(hit_b1), .hit_b2(hit_b2),
    .player_hp(player_hp), .monster_hp(monster_hp),
    .game_over(game_over), .game_win(game_win)
  );

  battle_sequencer #(
    .DODGE_FRAMES(8), .ATTACK_FRAMES(2), .PLAYER_HP_INIT(25),
    .MONSTER_HP_INIT(100), .BULLET_DAMAGE(10), .IFRAMES(2)
  ) u_dut2 (
    .Pclk(Pclk), .RESET(RESET), .frame_tick(frame_tick2), .start(start2),
    .ovl_b1(ovl2_b1), .ovl_b2(ovl2_b2), .attack(attack2), .attack_damage(attack_damage2),
    .state_game(state_game2), .hit_b1(hit2_b1), .hit_b2(hit2_b2),
    .player_hp(player_hp2), .monster_hp(monster_hp2),
    .game_over(game_over2), .game_win(game_win2)
  );

  task automatic cyc();
    @(posedge Pclk);
    #1;
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic tick2(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick2 = 1'b1; cyc(); frame_tick2 = 1'b0; cyc();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; start = 1'b1;
    cyc(); cyc();
    start = 1'b0;
    total++; if (state_game !== 1'b0) begin bad++; $display("FAIL rst_state_game: got %0b want 0", state_game); end
    total++; if (hit_b1 !== 1'b0) begin bad++; $display("FAIL rst_hit_b1: got %0b want 0", hit_b1); end
    total++; if (hit_b2 !== 1'b0) begin bad++; $display("FAIL rst_hit_b2: got %0b want 0", hit_b2); end
    total++; if (player_hp !== 7'd100) begin bad++; $display("FAIL rst_player_hp: got %0d want 100", player_hp); end
    total++; if (monster_hp !== 7'd100) begin bad++; $display("FAIL rst_monster_hp: got %0d want 100", monster_hp); end
    total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over: got %0b want 0", game_over); end
    total++; if (game_win !== 1'b0) begin bad++; $display("FAIL rst_game_win: got %0b want 0", game_win); end
    total++; if (player_hp2 !== 7'd25) begin bad++; $display("FAIL rst_player_hp2: got %0d want 25", player_hp2); end
    RESET = 1'b1;
    cyc();
    // IDLE must ignore overlaps
    ovl_b1 = 1'b1; cyc(); ovl_b1 = 1'b0;
    total++; if (hit_b1 !== 1'b0 || player_hp !== 7'd100) begin bad++; $display("FAIL idle_no_hit: got hit=%0b hp=%0d want hit=0 hp=100", hit_b1, player_hp); end
  endtask

  task automatic test_dodge_length();
    start = 1'b1; cyc(); start = 1'b0;
    tick1(299);
    total++; if (state_game !== 1'b0) begin bad++; $display("FAIL dodge_len_299: got %0b want 0", state_game); end
    tick1(1);
    total++; if (state_game !== 1'b1) begin bad++; $display("FAIL dodge_len_300: got %0b want 1", state_game); end
    total++; if (player_hp !== 7'd100 || monster_hp !== 7'd100) begin bad++; $display("FAIL dodge_len_hp: got %0d/%0d want 100/100", player_hp, monster_hp); end
  endtask

  task automatic test_attack();
    attack = 1'b1; attack_damage = 7'd40; cyc(); attack = 1'b0; attack_damage = 7'd0;
    total++; if (monster_hp !== 7'd100 || state_game !== 1'b1) begin bad++; $display("FAIL attack_c1: got hp=%0d sg=%0b want hp=100 sg=1", monster_hp, state_game); end
    cyc();
    total++; if (monster_hp !== 7'd60) begin bad++; $display("FAIL attack_c2_hp: got %0d want 60", monster_hp); end
    total++; if (state_game !== 1'b0) begin bad++; $display("FAIL attack_c2_sg: got %0b want 0", state_game); end
  endtask

  task automatic test_attack_ignored_in_dodge();
    attack = 1'b1; attack_damage = 7'd40; cyc(); attack = 1'b0; attack_damage = 7'd0; cyc();
    total++; if (monster_hp !== 7'd60 || state_game !== 1'b0) begin bad++; $display("FAIL dodge_attack_ignored: got hp=%0d sg=%0b want hp=60 sg=0", monster_hp, state_game); end
  endtask

  task automatic test_hold_b1();
    int pulses = 0;
    int b2s = 0;
    ovl_b1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (hit_b1 === 1'b1) pulses++;
      if (hit_b2 === 1'b1) b2s++;
    end
    ovl_b1 = 1'b0; cyc();
    if (hit_b1 === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL hold_b1_pulses: got %0d want 1", pulses); end
    total++; if (b2s !== 0) begin bad++; $display("FAIL hold_b1_no_b2: got %0d want 0", b2s); end
    total++; if (player_hp !== 7'd90) begin bad++; $display("FAIL hold_b1_hp: got %0d want 90", player_hp); end
    tick1(300);
    total++; if (state_game !== 1'b1) begin bad++; $display("FAIL phase_b_end: got %0b want 1", state_game); end
  endtask

  task automatic test_timeout_attack();
    tick1(179);
    total++; if (state_game !== 1'b1) begin bad++; $display("FAIL aim_before_timeout: got %0b want 1", state_game); end
    frame_tick = 1'b1; attack = 1'b1; attack_damage = 7'd25; cyc();
    frame_tick = 1'b0; attack = 1'b0; attack_damage = 7'd0; cyc();
    total++; if (monster_hp !== 7'd35) begin bad++; $display("FAIL timeout_attack_hp: got %0d want 35", monster_hp); end
    total++; if (state_game !== 1'b0) begin bad++; $display("FAIL timeout_attack_sg: got %0b want 0", state_game); end
  endtask

  task automatic test_both_overlap();
    ovl_b1 = 1'b1; ovl_b2 = 1'b1; cyc(); ovl_b1 = 1'b0; ovl_b2 = 1'b0;
    total++; if (hit_b1 !== 1'b1 || hit_b2 !== 1'b0) begin bad++; $display("FAIL both_ovl: got b1=%0b b2=%0b want b1=1 b2=0", hit_b1, hit_b2); end
    total++; if (player_hp !== 7'd80) begin bad++; $display("FAIL both_ovl_hp: got %0d want 80", player_hp); end
    cyc();
    total++; if (hit_b1 !== 1'b0) begin bad++; $display("FAIL hit_b1_pulse_width: got %0b want 0", hit_b1); end
    tick1(10);
    ovl_b2 = 1'b1; cyc(); ovl_b2 = 1'b0;
    total++; if (hit_b2 !== 1'b0 || player_hp !== 7'd80) begin bad++; $display("FAIL b2_iframe_10: got hit=%0b hp=%0d want hit=0 hp=80", hit_b2, player_hp); end
    tick1(19);
    ovl_b2 = 1'b1; cyc(); ovl_b2 = 1'b0;
    total++; if (hit_b2 !== 1'b0) begin bad++; $display("FAIL b2_iframe_29: got %0b want 0", hit_b2); end
    tick1(1);
    ovl_b2 = 1'b1; cyc(); ovl_b2 = 1'b0;
    total++; if (hit_b2 !== 1'b1 || player_hp !== 7'd70) begin bad++; $display("FAIL b2_iframe_30: got hit=%0b hp=%0d want hit=1 hp=70", hit_b2, player_hp); end
    tick1(270);
    total++; if (state_game !== 1'b1) begin bad++; $display("FAIL phase_c_end: got %0b want 1", state_game); end
    attack = 1'b1; attack_damage = 7'd25; cyc(); attack = 1'b0; attack_damage = 7'd0; cyc();
    total++; if (monster_hp !== 7'd10) begin bad++; $display("FAIL monster_to_10: got %0d want 10", monster_hp); end
  endtask

  task automatic test_win();
    tick1(300);
    attack = 1'b1; attack_damage = 7'd40; cyc(); attack = 1'b0; attack_damage = 7'd0; cyc();
    total++; if (monster_hp !== 7'd0) begin bad++; $display("FAIL win_hp: got %0d want 0", monster_hp); end
    total++; if (game_win !== 1'b1 || state_game !== 1'b0) begin bad++; $display("FAIL win_flags: got win=%0b sg=%0b want win=1 sg=0", game_win, state_game); end
    frame_tick = 1'b1; attack = 1'b1; attack_damage = 7'd5; cyc();
    frame_tick = 1'b0; attack = 1'b0; attack_damage = 7'd0; cyc();
    total++; if (monster_hp !== 7'd0 || game_win !== 1'b1 || player_hp !== 7'd70) begin bad++; $display("FAIL win_hold: got m=%0d win=%0b p=%0d want m=0 win=1 p=70", monster_hp, game_win, player_hp); end
    start = 1'b1; cyc(); start = 1'b0;
    total++; if (player_hp !== 7'd100 || monster_hp !== 7'd100 || game_win !== 1'b0) begin bad++; $display("FAIL win_restart: got %0d/%0d win=%0b want 100/100 win=0", player_hp, monster_hp, game_win); end
  endtask

  task automatic test_reset_mid_game();
    ovl_b1 = 1'b1; cyc(); ovl_b1 = 1'b0;
    total++; if (player_hp !== 7'd90) begin bad++; $display("FAIL mid_game_hit: got %0d want 90", player_hp); end
    RESET = 1'b0; start = 1'b1; cyc(); RESET = 1'b1; start = 1'b0;
    total++; if (player_hp !== 7'd100) begin bad++; $display("FAIL mid_reset_hp: got %0d want 100", player_hp); end
    ovl_b1 = 1'b1; cyc(); ovl_b1 = 1'b0;
    total++; if (hit_b1 !== 1'b0 || player_hp !== 7'd100) begin bad++; $display("FAIL reset_over_start: got hit=%0b hp=%0d want hit=0 hp=100", hit_b1, player_hp); end
  endtask

  task automatic test_lose();
    start2 = 1'b1; cyc(); start2 = 1'b0;
    ovl2_b1 = 1'b1; cyc(); ovl2_b1 = 1'b0;
    total++; if (player_hp2 !== 7'd15 || hit2_b1 !== 1'b1) begin bad++; $display("FAIL lose_hit1: got hp=%0d hit=%0b want hp=15 hit=1", player_hp2, hit2_b1); end
    tick2(1);
    ovl2_b2 = 1'b1; cyc(); ovl2_b2 = 1'b0;
    total++; if (hit2_b2 !== 1'b0) begin bad++; $display("FAIL lose_iframe: got %0b want 0", hit2_b2); end
    tick2(1);
    ovl2_b2 = 1'b1; cyc(); ovl2_b2 = 1'b0;
    total++; if (player_hp2 !== 7'd5 || hit2_b2 !== 1'b1) begin bad++; $display("FAIL lose_hit2: got hp=%0d hit=%0b want hp=5 hit=1", player_hp2, hit2_b2); end
    tick2(6);
    total++; if (state_game2 !== 1'b1) begin bad++; $display("FAIL lose_aim: got %0b want 1", state_game2); end
    attack2 = 1'b1; attack_damage2 = 7'd0; cyc(); attack2 = 1'b0; cyc();
    total++; if (monster_hp2 !== 7'd100 || state_game2 !== 1'b0) begin bad++; $display("FAIL lose_resolve: got m=%0d sg=%0b want m=100 sg=0", monster_hp2, state_game2); end
    ovl2_b1 = 1'b1; cyc(); ovl2_b1 = 1'b0;
    total++; if (player_hp2 !== 7'd0 || hit2_b1 !== 1'b1) begin bad++; $display("FAIL lose_sat: got hp=%0d hit=%0b want hp=0 hit=1", player_hp2, hit2_b1); end
    total++; if (game_over2 !== 1'b1) begin bad++; $display("FAIL lose_game_over: got %0b want 1", game_over2); end
    ovl2_b2 = 1'b1; frame_tick2 = 1'b1; cyc(); ovl2_b2 = 1'b0; frame_tick2 = 1'b0; cyc();
    total++; if (player_hp2 !== 7'd0 || hit2_b2 !== 1'b0 || game_over2 !== 1'b1) begin bad++; $display("FAIL lose_hold: got hp=%0d b2=%0b over=%0b want 0/0/1", player_hp2, hit2_b2, game_over2); end
    start2 = 1'b1; cyc(); start2 = 1'b0;
    total++; if (player_hp2 !== 7'd25 || monster_hp2 !== 7'd100 || game_over2 !== 1'b0) begin bad++; $display("FAIL lose_restart: got %0d/%0d over=%0b want 25/100 over=0", player_hp2, monster_hp2, game_over2); end
    ovl2_b1 = 1'b1; cyc(); ovl2_b1 = 1'b0;
    total++; if (player_hp2 !== 7'd15 || state_game2 !== 1'b0) begin bad++; $display("FAIL lose_restart_dodge: got hp=%0d sg=%0b want hp=15 sg=0", player_hp2, state_game2); end
  endtask

  initial begin
    RESET = 1'b0; frame_tick = 1'b0; start = 1'b0; ovl_b1 = 1'b0; ovl_b2 = 1'b0;
    attack = 1'b0; attack_damage = 7'd0;
    frame_tick2 = 1'b0; start2 = 1'b0; ovl2_b1 = 1'b0; ovl2_b2 = 1'b0;
    attack2 = 1'b0; attack_damage2 = 7'd0;
    test_reset();
    test_dodge_length();
    test_attack();
    test_attack_ignored_in_dodge();
    test_hold_b1();
    test_timeout_attack();
    test_both_overlap();
    test_win();
    test_reset_mid_game();
    test_lose();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/battle_sequencer.md
# battle_sequencer

Frame-synchronous battle controller that sequences the game between the dodge phase (bee vs. bullets) and the attack phase (pangya timing bar), and owns the player and monster HP registers. It replaces the free-running phase timer and the ad-hoc per-pixel collision latches in the top level. It consumes raw per-pixel sprite-overlap flags and the attack result, and produces debounced once-per-phase hit pulses, the phase select, and both HP values for the bar renderers. Runs on the 25 MHz pixel clock.

## Interface
- DODGE_FRAMES, 300: dodge-phase length in frames
- ATTACK_FRAMES, 180: attack-phase window in frames before auto-timeout
- PLAYER_HP_INIT, 100: player HP loaded on start (≤127)
- MONSTER_HP_INIT, 100: monster HP loaded on start (≤127)
- BULLET_DAMAGE, 10: player HP removed per accepted bullet hit
- IFRAMES, 30: invulnerability frames after an accepted hit

- Pclk  in  1  pixel clock, 25 MHz; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- start  in  1  one-cycle pulse; begins or restarts a game
- ovl_b1  in  1  bee and bullet 1 overlap at the current pixel
- ovl_b2  in  1  bee and bullet 2 overlap at the current pixel
- attack  in  1  one-cycle pulse; player pressed attack
- attack_damage  in  7  damage value, valid in the cycle `attack` is high
- state_game  out  1  0 = dodge screen, 1 = attack screen
- hit_b1  out  1  one-cycle pulse, bullet 1 hit accepted
- hit_b2  out  1  one-cycle pulse, bullet 2 hit accepted
- player_hp  out  7  current player HP
- monster_hp  out  7  current monster HP
- game_over  out  1  high in LOSE
- game_win  out  1  high in WIN

## Operation
- States: IDLE, DODGE, AIM, RESOLVE, LOSE, WIN. `frame_cnt` is 9 bits. `iframe_cnt` is 6 bits. `dmg_q` is 7 bits. Latches `b1_done` and `b2_done`.
- IDLE: wait for `start`.
  - On `start`: load both HP values from their init parameters, set `frame_cnt` = DODGE_FRAMES−1, clear `iframe_cnt`, clear both done latches, go to DODGE.
- DODGE:
  - On `frame_tick`: if `frame_cnt`==0, go to AIM and load `frame_cnt` = ATTACK_FRAMES−1. Otherwise decrement `frame_cnt`.
  - On `frame_tick`: decrement `iframe_cnt` if it is nonzero.
  - Bullet 1 hit is accepted when `ovl_b1` is high, `b1_done`==0 and `iframe_cnt`==0. On acceptance: pulse `hit_b1`, set `b1_done`, set `iframe_cnt` = IFRAMES, and set `player_hp` = max(player_hp − BULLET_DAMAGE, 0).
  - Bullet 2 hit is accepted by the same rule using `ovl_b2` and `b2_done`.
  - If both overlaps qualify in the same cycle, only b1 is accepted. The iframe window then blocks b2.
  - If the saturated HP result is 0, go to LOSE on the next cycle. This overrides the `frame_tick` transition.
  - `attack` is ignored in DODGE.
- AIM:
  - On `attack`: latch `dmg_q` ← `attack_damage`, go to RESOLVE.
  - On `frame_tick` with `frame_cnt`==0: latch `dmg_q` ← 0, go to RESOLVE. Otherwise `frame_tick` decrements `frame_cnt`.
  - `attack` and timeout in the same cycle: `attack` wins.
  - `ovl_*` inputs are ignored.
- RESOLVE (one cycle):
  - Set `monster_hp` = max(monster_hp − dmg_q, 0).
  - If the result is 0, go to WIN.
  - Otherwise go to DODGE with `frame_cnt` = DODGE_FRAMES−1, both done latches cleared and `iframe_cnt` cleared.
- LOSE / WIN: hold all HP values. `start` re-initialises exactly as from IDLE.
- `start` in DODGE, AIM or RESOLVE also restarts the game immediately, with priority over every other event.
- All subtraction is 8-bit internally with a borrow check. HP never wraps.

## Timing
- All outputs are registered.
- Reset values: `state_game`=0, `hit_b1`=0, `hit_b2`=0, `player_hp`=PLAYER_HP_INIT, `monster_hp`=MONSTER_HP_INIT, `game_over`=0, `game_win`=0. State after reset is IDLE.
- `hit_b*` asserts in the cycle after the qualifying `ovl_b*` sample. `player_hp` updates in that same cycle.
- `state_game` changes in the cycle after the transition event.
  - It is 1 in AIM and RESOLVE.
  - It is 0 in all other states.
- From `attack` to the `monster_hp` update is 2 cycles: AIM→RESOLVE, then the RESOLVE write.
- RESET low mid-game aborts on the next edge. It overrides `start`.
- The dodge phase lasts exactly DODGE_FRAMES `frame_tick` pulses after entry.

## Test plan
- Reset, then `start`, then 300 `frame_tick` pulses with no overlap:
  - `state_game` rises after tick 300.
  - HP stays 100/100.
- In DODGE, hold `ovl_b1` high for 50 cycles:
  - Exactly one `hit_b1` pulse.
  - `player_hp` = 90.
- Assert `ovl_b1` and `ovl_b2` in the same cycle:
  - `hit_b1` only.
  - Assert `ovl_b2` 10 frames later: no hit.
  - Assert `ovl_b2` 30 frames later: `hit_b2` fires and `player_hp` = 80.
- In AIM, pulse `attack` with damage 40:
  - 2 cycles later `monster_hp` = 60.
  - Then DODGE, `state_game` = 0.
- AIM timeout, with `attack` coincident with the final `frame_tick` and damage 25:
  - `monster_hp` drops by 25, not 0.
- Drive `monster_hp` to 10 and attack with damage 40:
  - `monster_hp` = 0 and `game_win` = 1.
- Drive `player_hp` to 5, then hit:
  - `player_hp` = 0 and `game_over` = 1.
- Pulse `start` in LOSE:
  - HP = 100/100 and state is DODGE.
